// File: rtl/tile_display.sv
// -----------------------------------------------------------------------------
// tile_display
//
// Tile-based video fetch pipeline with a scroll/control register block.
// Owns the framebuffer (tile-index map, two 8-bit indices per 16-bit word)
// and the tile pixel RAM. CPU writes and reads share one memory-mapped port.
// The raster position from the VGA timing generator is turned into a
// registered pixel colour three cycles later.
//
// Ports
//   clk, rst_n              system clock, asynchronous active-low reset
//   wen, waddr, wdata       CPU write (tile RAM, framebuffer, registers)
//   ren, raddr              CPU read request
//   rdata, rvalid           read data (held while rvalid=0), one-cycle strobe
//   pixel_x, pixel_y        raster position
//   active                  high in the visible area
//   frame_start             one-cycle pulse per frame, counted in FRAME
//   pixel, pixel_valid      output colour, pixel_valid = active delayed 3
//
// Register block at REG_BASE:
//   +0 SCROLL_X  +1 SCROLL_Y  +2 CTRL (bit0 display enable)  +3 FRAME (RO)
//
// RAM contents are never reset. The tile RAM is filled by CPU writes or by
// the memory initialisation flow of the target technology.
// -----------------------------------------------------------------------------
module tile_display #(
    parameter int          TILE_LOG2  = 3,
    parameter int          MAP_W_LOG2 = 7,
    parameter int          MAP_H_LOG2 = 6,
    parameter int          TILES_LOG2 = 7,
    parameter int          PIXEL_W    = 12,
    parameter logic [15:0] TM_BASE    = 16'hc000,
    parameter logic [15:0] FB_BASE    = 16'he000,
    parameter logic [15:0] REG_BASE   = 16'hf010
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wen,
    input  logic [15:0]        waddr,
    input  logic [15:0]        wdata,
    input  logic               ren,
    input  logic [15:0]        raddr,
    output logic [15:0]        rdata,
    output logic               rvalid,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic               active,
    input  logic               frame_start,
    output logic [PIXEL_W-1:0] pixel,
    output logic               pixel_valid
);

    localparam int T        = TILE_LOG2;
    localparam int SX_W     = MAP_W_LOG2 + TILE_LOG2;
    localparam int SY_W     = MAP_H_LOG2 + TILE_LOG2;
    localparam int TM_AW    = TILES_LOG2 + 2 * TILE_LOG2;
    localparam int FB_AW    = MAP_W_LOG2 + MAP_H_LOG2 - 1;
    localparam int TM_DEPTH = 1 << TM_AW;
    localparam int FB_DEPTH = 1 << FB_AW;
    localparam int STAGES   = 3;

    // Read-source selector for the registered CPU read path
    localparam logic [1:0] RS_NONE = 2'd0;
    localparam logic [1:0] RS_TM   = 2'd1;
    localparam logic [1:0] RS_FB   = 2'd2;
    localparam logic [1:0] RS_REG  = 2'd3;

    function automatic logic in_range(input logic [15:0] a,
                                      input logic [15:0] base,
                                      input int          depth);
        return (int'(a) >= int'(base)) && (int'(a) < int'(base) + depth);
    endfunction

    // ---------------------------------------------------------------- decode
    logic             w_tm, w_fb, w_reg;
    logic             r_tm, r_fb, r_reg;
    logic [TM_AW-1:0] w_tm_a, r_tm_a;
    logic [FB_AW-1:0] w_fb_a, r_fb_a;
    logic [1:0]       w_reg_a, r_reg_a;

    assign w_tm    = wen && in_range(waddr, TM_BASE, TM_DEPTH);
    assign w_fb    = wen && in_range(waddr, FB_BASE, FB_DEPTH);
    assign w_reg   = wen && in_range(waddr, REG_BASE, 4);
    assign r_tm    = in_range(raddr, TM_BASE, TM_DEPTH);
    assign r_fb    = in_range(raddr, FB_BASE, FB_DEPTH);
    assign r_reg   = in_range(raddr, REG_BASE, 4);

    assign w_tm_a  = TM_AW'(waddr - TM_BASE);
    assign w_fb_a  = FB_AW'(waddr - FB_BASE);
    assign w_reg_a = 2'(waddr - REG_BASE);
    assign r_tm_a  = TM_AW'(raddr - TM_BASE);
    assign r_fb_a  = FB_AW'(raddr - FB_BASE);
    assign r_reg_a = 2'(raddr - REG_BASE);

    // ------------------------------------------------------------- registers
    logic [15:0] scroll_x, scroll_y, frame_cnt;
    logic        ctrl_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scroll_x  <= '0;
            scroll_y  <= '0;
            ctrl_en   <= 1'b1;
            frame_cnt <= '0;
        end else begin
            if (frame_start) frame_cnt <= frame_cnt + 16'd1;
            if (w_reg) begin
                case (w_reg_a)
                    2'd0:    scroll_x <= wdata;
                    2'd1:    scroll_y <= wdata;
                    2'd2:    ctrl_en  <= wdata[0];
                    default: ;  // FRAME is read-only
                endcase
            end
        end
    end

    // ------------------------------------------------- S0: scroll and FB addr
    logic [SX_W-1:0]       sx;
    logic [SY_W-1:0]       sy;
    logic [MAP_W_LOG2-1:0] tx;
    logic [FB_AW-1:0]      fb_rd_a;

    // Truncation to the map size in pixels gives the toroidal wrap for free
    assign sx      = SX_W'(pixel_x) + SX_W'(scroll_x);
    assign sy      = SY_W'(pixel_y) + SY_W'(scroll_y);
    assign tx      = sx[SX_W-1:T];
    // Cell = ty*W + tx; two cells per word, so tx[0] picks the byte
    assign fb_rd_a = {sy[SY_W-1:T], tx[MAP_W_LOG2-1:1]};

    logic [15:0]           fb_mem [FB_DEPTH];
    logic [TILES_LOG2-1:0] fb_lo_q, fb_hi_q;
    logic [15:0]           fb_cpu_q;

    // Read-first: reads see the word as it was before a same-edge write
    always_ff @(posedge clk) begin
        if (w_fb) fb_mem[w_fb_a] <= wdata;
        fb_lo_q <= fb_mem[fb_rd_a][TILES_LOG2-1:0];
        fb_hi_q <= fb_mem[fb_rd_a][8 +: TILES_LOG2];
        if (ren && r_fb) fb_cpu_q <= fb_mem[r_fb_a];
    end

    logic              sel_q;
    logic [T-1:0]      fx_q, fy_q;
    logic [STAGES:1]   vld_pipe;
    // Enable travels with the pixel so a CTRL write only affects later coords
    logic [STAGES-1:1] en_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= 1'b0;
            fx_q     <= '0;
            fy_q     <= '0;
            vld_pipe <= '0;
            en_pipe  <= '0;
        end else begin
            sel_q    <= tx[0];
            fx_q     <= sx[T-1:0];
            fy_q     <= sy[T-1:0];
            vld_pipe <= {vld_pipe[STAGES-1:1], active};
            en_pipe  <= {en_pipe[STAGES-2:1], ctrl_en};
        end
    end

    // ---------------------------------------------- S1: index select, tile rd
    logic [TILES_LOG2-1:0] idx;
    logic [TM_AW-1:0]      tm_rd_a;

    // Only the stored index bits are kept, which is the tile-count mask
    assign idx     = sel_q ? fb_hi_q : fb_lo_q;
    assign tm_rd_a = {idx, fy_q, fx_q};

    logic [15:0]        tm_mem [TM_DEPTH];
    logic [PIXEL_W-1:0] tm_pix_q;
    logic [15:0]        tm_cpu_q;

    always_ff @(posedge clk) begin
        if (w_tm) tm_mem[w_tm_a] <= wdata;
        tm_pix_q <= tm_mem[tm_rd_a][PIXEL_W-1:0];
        if (ren && r_tm) tm_cpu_q <= tm_mem[r_tm_a];
    end

    // ----------------------------------------------------- S2: output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel <= '0;
        end else begin
            pixel <= (vld_pipe[STAGES-1] && en_pipe[STAGES-1]) ? tm_pix_q : '0;
        end
    end

    assign pixel_valid = vld_pipe[STAGES];

    // -------------------------------------------------------- CPU read path
    logic [15:0] reg_rd, reg_rd_q, rd_mux, rdata_hold;
    logic [1:0]  rsel_q;

    always_comb begin
        reg_rd = '0;
        case (r_reg_a)
            2'd0:    reg_rd = scroll_x;
            2'd1:    reg_rd = scroll_y;
            2'd2:    reg_rd = {15'd0, ctrl_en};
            default: reg_rd = frame_cnt;  // pre-increment value on a pulse
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid     <= 1'b0;
            rsel_q     <= RS_NONE;
            reg_rd_q   <= '0;
            rdata_hold <= '0;
        end else begin
            rvalid     <= ren;
            rdata_hold <= rdata;
            if (ren) begin
                rsel_q <= r_tm ? RS_TM : r_fb ? RS_FB : r_reg ? RS_REG : RS_NONE;
                if (r_reg) reg_rd_q <= reg_rd;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rsel_q)
            RS_TM:   rd_mux = tm_cpu_q;
            RS_FB:   rd_mux = fb_cpu_q;
            RS_REG:  rd_mux = reg_rd_q;
            default: rd_mux = '0;
        endcase
    end

    // Hold the last returned word between strobes
    assign rdata = rvalid ? rd_mux : rdata_hold;

endmodule

// File: tb/tb_tile_display.sv
// -----------------------------------------------------------------------------
// tb_tile_display: directed self-checking bench for tile_display with the
// default geometry (8x8 tiles, 128x64 map, 128 tiles, 12-bit colour).
// -----------------------------------------------------------------------------
module tb_tile_display;

    logic        clk;
    logic        rst_n;
    logic        wen;
    logic [15:0] waddr, wdata;
    logic        ren;
    logic [15:0] raddr;
    logic [15:0] rdata;
    logic        rvalid;
    logic [9:0]  pixel_x, pixel_y;
    logic        active;
    logic        frame_start;
    logic [11:0] pixel;
    logic        pixel_valid;

    int total = 0;
    int bad   = 0;

    localparam logic [15:0] R_SX    = 16'hf010;
    localparam logic [15:0] R_SY    = 16'hf011;
    localparam logic [15:0] R_CTRL  = 16'hf012;
    localparam logic [15:0] R_FRAME = 16'hf013;

    tile_display dut (
        .clk(clk), .rst_n(rst_n),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .active(active),
        .frame_start(frame_start),
        .pixel(pixel), .pixel_valid(pixel_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        wen = 1'b1; waddr = a; wdata = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [15:0] d,
                            output logic v);
        ren = 1'b1; raddr = a;
        tick();
        d = rdata; v = rvalid;
        ren = 1'b0;
    endtask

    // Present one active pixel then go idle; returns after the third edge
    task automatic show_one(input logic [9:0] x, input logic [9:0] y);
        pixel_x = x; pixel_y = y; active = 1'b1;
        tick();
        active = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic        v;
        active = 1'b1;
        repeat (4) tick();
        total++;
        if (pixel_valid !== 1'b1) begin
            bad++; $display("FAIL pre_reset_valid got=%b exp=1", pixel_valid);
        end
        #3 rst_n = 1'b0;
        #2;
        total++;
        if (pixel !== 12'h0 || pixel_valid !== 1'b0 || rdata !== 16'h0 || rvalid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset pixel=%h valid=%b rdata=%h rvalid=%b exp all 0",
                     pixel, pixel_valid, rdata, rvalid);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (pixel_valid !== 1'b0) begin
            bad++; $display("FAIL first_valid_early got=%b exp=0", pixel_valid);
        end
        tick();
        total++;
        if (pixel_valid !== 1'b1) begin
            bad++; $display("FAIL first_valid_3cyc got=%b exp=1", pixel_valid);
        end
        active = 1'b0;
        repeat (3) tick();

        cpu_read(R_CTRL, d, v);
        total++;
        if (d !== 16'h0001 || v !== 1'b1) begin
            bad++; $display("FAIL ctrl_reset got=%h/%b exp=0001/1", d, v);
        end
        tick();
        total++;
        if (rvalid !== 1'b0 || rdata !== 16'h0001) begin
            bad++; $display("FAIL rvalid_pulse rvalid=%b rdata=%h exp 0/0001", rvalid, rdata);
        end
        cpu_read(16'hf100, d, v);
        total++;
        if (d !== 16'h0 || v !== 1'b1) begin
            bad++; $display("FAIL unmapped_read got=%h/%b exp=0000/1", d, v);
        end
        cpu_read(R_SX, d, v);
        total++;
        if (d !== 16'h0) begin bad++; $display("FAIL sx_reset got=%h exp=0000", d); end
        cpu_read(R_FRAME, d, v);
        total++;
        if (d !== 16'h0) begin bad++; $display("FAIL frame_reset got=%h exp=0000", d); end
    endtask

    task automatic test_basic_fetch();
        cpu_write(16'he000, 16'h0302);   // cell0 -> tile 2, cell1 -> tile 3
        cpu_write(16'he001, 16'h0082);   // cell2 -> 0x82, masked to tile 2
        cpu_write(16'hc080, 16'h0a0b);   // tile 2 px(0,0)
        cpu_write(16'hc081, 16'h0a0c);
        cpu_write(16'hc0c0, 16'h0fff);   // tile 3 px(0,0)
        pixel_x = 10'd0; pixel_y = 10'd0; active = 1'b1;
        tick();
        pixel_x = 10'd8;
        tick();
        active = 1'b0;
        total++;
        if (pixel_valid !== 1'b0) begin
            bad++; $display("FAIL fetch_latency valid=%b exp=0 after 2 edges", pixel_valid);
        end
        tick();
        total++;
        if (pixel !== 12'ha0b || pixel_valid !== 1'b1) begin
            bad++; $display("FAIL fetch_tile2 got=%h/%b exp=a0b/1", pixel, pixel_valid);
        end
        tick();
        total++;
        if (pixel !== 12'hfff || pixel_valid !== 1'b1) begin
            bad++; $display("FAIL fetch_tile3 got=%h/%b exp=fff/1", pixel, pixel_valid);
        end
        show_one(10'd17, 10'd0);          // cell 2, fx=1
        total++;
        if (pixel !== 12'ha0c) begin
            bad++; $display("FAIL index_mask got=%h exp=a0c", pixel);
        end
    endtask

    task automatic test_scroll_wrap();
        logic [15:0] d;
        logic        v;
        cpu_write(16'hc086, 16'h0123);   // tile 2 px(6,0)
        cpu_write(R_SX, 16'd1020);
        show_one(10'd10, 10'd0);          // sx = 1030 mod 1024 = 6
        total++;
        if (pixel !== 12'h123) begin
            bad++; $display("FAIL scroll_x_wrap got=%h exp=123", pixel);
        end
        cpu_write(R_SX, 16'h0000);
        cpu_write(16'hefc0, 16'h0005);   // cell 63*128 -> tile 5
        cpu_write(16'hc178, 16'h0456);   // tile 5 px(0,7)
        cpu_write(R_SY, 16'hffff);
        show_one(10'd0, 10'd0);           // sy = 511
        total++;
        if (pixel !== 12'h456) begin
            bad++; $display("FAIL scroll_y_wrap got=%h exp=456", pixel);
        end
        cpu_read(R_SY, d, v);
        total++;
        if (d !== 16'hffff) begin bad++; $display("FAIL sy_readback got=%h exp=ffff", d); end
        cpu_write(R_SY, 16'h0000);
    endtask

    task automatic test_enable();
        logic [15:0] d;
        logic        v;
        cpu_write(R_CTRL, 16'hfffe);
        cpu_read(R_CTRL, d, v);
        total++;
        if (d !== 16'h0000) begin bad++; $display("FAIL ctrl_mask got=%h exp=0000", d); end
        show_one(10'd0, 10'd0);
        total++;
        if (pixel !== 12'h0 || pixel_valid !== 1'b1) begin
            bad++; $display("FAIL disabled got=%h/%b exp=000/1", pixel, pixel_valid);
        end
        cpu_write(R_CTRL, 16'h0001);
        pixel_x = 10'd0; pixel_y = 10'd0; active = 1'b0;
        repeat (3) tick();
        total++;
        if (pixel !== 12'h0 || pixel_valid !== 1'b0) begin
            bad++; $display("FAIL blank got=%h/%b exp=000/0", pixel, pixel_valid);
        end
    endtask

    task automatic test_collision();
        logic [15:0] d;
        logic        v;
        cpu_write(16'hc100, 16'h0777);   // tile 4 px(0,0)
        pixel_x = 10'd0; pixel_y = 10'd0; active = 1'b1;
        wen = 1'b1; waddr = 16'he000; wdata = 16'h0304;
        tick();
        wen = 1'b0; active = 1'b0;
        tick();
        tick();
        total++;
        if (pixel !== 12'ha0b) begin
            bad++; $display("FAIL fb_collision_old got=%h exp=a0b", pixel);
        end
        show_one(10'd0, 10'd0);
        total++;
        if (pixel !== 12'h777) begin
            bad++; $display("FAIL fb_collision_new got=%h exp=777", pixel);
        end
        wen = 1'b1; waddr = 16'hc0c0; wdata = 16'h0bbb;
        ren = 1'b1; raddr = 16'hc0c0;
        tick();
        wen = 1'b0; ren = 1'b0;
        total++;
        if (rdata !== 16'h0fff || rvalid !== 1'b1) begin
            bad++; $display("FAIL tm_collision got=%h/%b exp=0fff/1", rdata, rvalid);
        end
        cpu_read(16'hc0c0, d, v);
        total++;
        if (d !== 16'h0bbb) begin bad++; $display("FAIL tm_after_write got=%h exp=0bbb", d); end
    endtask

    task automatic test_back_to_back();
        ren = 1'b1; raddr = R_CTRL;
        tick();
        raddr = 16'he000;
        total++;
        if (rdata !== 16'h0001 || rvalid !== 1'b1) begin
            bad++; $display("FAIL b2b_first got=%h/%b exp=0001/1", rdata, rvalid);
        end
        tick();
        ren = 1'b0;
        total++;
        if (rdata !== 16'h0304 || rvalid !== 1'b1) begin
            bad++; $display("FAIL b2b_second got=%h/%b exp=0304/1", rdata, rvalid);
        end
        tick();
        total++;
        if (rdata !== 16'h0304 || rvalid !== 1'b0) begin
            bad++; $display("FAIL b2b_hold got=%h/%b exp=0304/0", rdata, rvalid);
        end
    endtask

    task automatic test_frame();
        logic [15:0] d;
        logic        v;
        for (int i = 0; i < 3; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
        cpu_read(R_FRAME, d, v);
        total++;
        if (d !== 16'd3) begin bad++; $display("FAIL frame_count got=%h exp=0003", d); end
        cpu_write(R_FRAME, 16'h1234);
        cpu_read(R_FRAME, d, v);
        total++;
        if (d !== 16'd3) begin bad++; $display("FAIL frame_ro got=%h exp=0003", d); end
        frame_start = 1'b1; ren = 1'b1; raddr = R_FRAME;
        tick();
        frame_start = 1'b0; ren = 1'b0;
        total++;
        if (rdata !== 16'd3) begin bad++; $display("FAIL frame_coincident got=%h exp=0003", rdata); end
        cpu_read(R_FRAME, d, v);
        total++;
        if (d !== 16'd4) begin bad++; $display("FAIL frame_post got=%h exp=0004", d); end
        frame_start = 1'b1;
        repeat (65531) tick();
        frame_start = 1'b0;
        cpu_read(R_FRAME, d, v);
        total++;
        if (d !== 16'hffff) begin bad++; $display("FAIL frame_max got=%h exp=ffff", d); end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        cpu_read(R_FRAME, d, v);
        total++;
        if (d !== 16'h0000) begin bad++; $display("FAIL frame_wrap got=%h exp=0000", d); end
    endtask

    initial begin
        rst_n = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
        ren = 1'b0; raddr = '0; pixel_x = '0; pixel_y = '0;
        active = 1'b0; frame_start = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_basic_fetch();
        test_scroll_wrap();
        test_enable();
        test_collision();
        test_back_to_back();
        test_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
